// File: rtl/lsu_mem_access.sv
// Memory-access stage: turns registered load/store control into AXI4-Lite
// read/write transactions and extends load data to register width.
module lsu_mem_access #(
  parameter int RegWidth = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lsu_valid,
  input  logic                i_MemWr,
  input  logic                i_MemRd,
  input  logic [2:0]          i_MemOP,
  input  logic [RegWidth-1:0] i_addr,
  input  logic [RegWidth-1:0] i_wdata,
  input  logic                pipeline_flush,
  output logic                lsu_ready,
  output logic                lsu_to_wbu_valid,
  input  logic                wbu_allow_in,
  output logic [RegWidth-1:0] o_rdata,
  output logic [RegWidth-1:0] araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [RegWidth-1:0] rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [RegWidth-1:0] awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [RegWidth-1:0] wdata,
  output logic [7:0]          wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_t;

  state_t              state, state_nxt;
  logic                flushed, flushed_nxt;
  logic                aw_done, aw_done_nxt;
  logic                w_done, w_done_nxt;
  logic                capture, rd_capture;
  logic                aw_fin, w_fin;
  logic [RegWidth-1:0] addr_p1, wdata_p1;
  logic [2:0]          op_p1;
  logic [7:0]          wstrb_p1;

  // Bus responses carry no information this stage acts on.
  logic unused_resp;
  assign unused_resp = ^{rresp, bresp};

  // Byte-enable mask for a store of the given size starting at the given lane;
  // lanes beyond 7 fall off the top.
  function automatic logic [7:0] lane_strb(input logic [1:0] size, input logic [2:0] lane);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lane;
  endfunction

  // Align read data to bit 0 and sign- or zero-extend it per MemOP.
  function automatic logic [RegWidth-1:0] load_extend(input logic [RegWidth-1:0] raw,
                                                      input logic [2:0] lane,
                                                      input logic [2:0] op);
    logic [RegWidth-1:0]        sh;
    logic signed [7:0]          b;
    logic signed [15:0]         h;
    logic signed [31:0]         w;
    logic signed [RegWidth-1:0] ext;
    sh = raw >> {lane, 3'b000};
    b  = signed'(sh[7:0]);
    h  = signed'(sh[15:0]);
    w  = signed'(sh[31:0]);
    case (op)
      3'b000:  ext = b;
      3'b001:  ext = h;
      3'b010:  ext = w;
      3'b100:  ext = signed'(RegWidth'(sh[7:0]));
      3'b101:  ext = signed'(RegWidth'(sh[15:0]));
      3'b110:  ext = signed'(RegWidth'(sh[31:0]));
      default: ext = signed'(sh);
    endcase
    return unsigned'(ext);
  endfunction

  assign araddr = addr_p1;
  assign awaddr = addr_p1;
  assign wdata  = wdata_p1;
  assign wstrb  = wstrb_p1;

  // Next-state, handshake decode and stage valid/ready.
  always_comb begin
    state_nxt        = state;
    flushed_nxt      = flushed;
    aw_done_nxt      = aw_done;
    w_done_nxt       = w_done;
    capture          = 1'b0;
    rd_capture       = 1'b0;
    lsu_ready        = 1'b0;
    lsu_to_wbu_valid = 1'b0;
    arvalid          = 1'b0;
    rready           = 1'b0;
    awvalid          = 1'b0;
    wvalid           = 1'b0;
    bready           = 1'b0;
    aw_fin           = 1'b0;
    w_fin            = 1'b0;
    unique case (state)
      IDLE: begin
        if (lsu_valid && !pipeline_flush) begin
          if (i_MemRd || i_MemWr) begin
            capture     = 1'b1;
            aw_done_nxt = 1'b0;
            w_done_nxt  = 1'b0;
            state_nxt   = i_MemRd ? RADDR : WREQ;
          end else begin
            lsu_to_wbu_valid = 1'b1;
            lsu_ready        = wbu_allow_in;
          end
        end
      end
      RADDR: begin
        arvalid = 1'b1;
        if (pipeline_flush) flushed_nxt = 1'b1;
        if (arready) state_nxt = RDATA;
      end
      RDATA: begin
        rready = 1'b1;
        if (rvalid) begin
          if (flushed || pipeline_flush) begin
            flushed_nxt = 1'b0;
            state_nxt   = IDLE;
          end else begin
            rd_capture = 1'b1;
            state_nxt  = DONE;
          end
        end else if (pipeline_flush) begin
          flushed_nxt = 1'b1;
        end
      end
      WREQ: begin
        awvalid     = !aw_done;
        wvalid      = !w_done;
        aw_fin      = aw_done || awready;
        w_fin       = w_done || wready;
        aw_done_nxt = aw_fin;
        w_done_nxt  = w_fin;
        if (pipeline_flush) flushed_nxt = 1'b1;
        if (aw_fin && w_fin) state_nxt = WRESP;
      end
      WRESP: begin
        bready = 1'b1;
        if (bvalid) begin
          flushed_nxt = 1'b0;
          state_nxt   = (flushed || pipeline_flush) ? IDLE : DONE;
        end else if (pipeline_flush) begin
          flushed_nxt = 1'b1;
        end
      end
      DONE: begin
        if (pipeline_flush) begin
          state_nxt = IDLE;
        end else begin
          lsu_to_wbu_valid = 1'b1;
          lsu_ready        = wbu_allow_in;
          if (wbu_allow_in) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      lsu_ready        = 1'b0;
      lsu_to_wbu_valid = 1'b0;
    end
  end

  // FSM state, flush flag, write-channel sticky bits and load result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      flushed <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      o_rdata <= '0;
    end else begin
      state   <= state_nxt;
      flushed <= flushed_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
      if (rd_capture) o_rdata <= load_extend(rdata, addr_p1[2:0], op_p1);
    end
  end

  // Latch address, op and lane-aligned store data when a memory op is accepted.
  always_ff @(posedge clk) begin
    if (capture) begin
      addr_p1  <= i_addr;
      op_p1    <= i_MemOP;
      wdata_p1 <= i_wdata << {i_addr[2:0], 3'b000};
      wstrb_p1 <= lane_strb(i_MemOP[1:0], i_addr[2:0]);
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
module tb_lsu_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid, i_MemWr, i_MemRd, pipeline_flush, wbu_allow_in;
  logic [2:0]  i_MemOP;
  logic [63:0] i_addr, i_wdata;
  logic        lsu_ready, lsu_to_wbu_valid;
  logic [63:0] o_rdata, araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready;
  logic        wvalid, wready, bvalid, bready;
  logic [7:0]  wstrb;
  logic [1:0]  rresp, bresp;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  int n;

  lsu_mem_access #(.RegWidth(64)) dut (
    .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .i_MemWr(i_MemWr), .i_MemRd(i_MemRd),
    .i_MemOP(i_MemOP), .i_addr(i_addr), .i_wdata(i_wdata), .pipeline_flush(pipeline_flush),
    .lsu_ready(lsu_ready), .lsu_to_wbu_valid(lsu_to_wbu_valid), .wbu_allow_in(wbu_allow_in),
    .o_rdata(o_rdata), .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata(rdata),
    .rresp(rresp), .rvalid(rvalid), .rready(rready), .awaddr(awaddr), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_pop(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, o_rdata, e);
    end
  endtask

  // Present a load (zero-wait slave unless caller changed handshakes) and
  // count edges until the stage reports a valid result.
  task automatic issue_load(input logic [63:0] addr, input logic [2:0] op,
                            input logic [63:0] rd, input logic [63:0] exp);
    lsu_valid = 1'b1; i_MemRd = 1'b1; i_MemWr = 1'b0;
    i_addr = addr; i_MemOP = op; rdata = rd;
    exp_q.push_back(exp);
    settle();
    n = 0;
    while (!lsu_to_wbu_valid && n < 20) begin
      next(); settle(); n++;
    end
  endtask

  task automatic idle_inputs();
    lsu_valid = 1'b0; i_MemRd = 1'b0; i_MemWr = 1'b0; pipeline_flush = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    lsu_valid = 1'b1; i_MemWr = 1'b0; i_MemRd = 1'b0; i_MemOP = 3'b0;
    i_addr = '0; i_wdata = '0; pipeline_flush = 1'b0; wbu_allow_in = 1'b1;
    arready = 1'b0; rdata = '0; rresp = 2'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b0; bvalid = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_valid", {63'b0, lsu_to_wbu_valid}, 64'd0);
    check("rst_ready", {63'b0, lsu_ready}, 64'd0);
    check("rst_axi", {59'b0, arvalid, rready, awvalid, wvalid, bready}, 64'd0);
    check("rst_rdata", o_rdata, 64'd0);
    next(); next();
    rst = 1'b0; idle_inputs();
    arready = 1'b1; rvalid = 1'b1;

    // lb with sign extension, zero-wait slave
    next();
    issue_load(64'h8000_0003, 3'b000, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_latency", 64'(n), 64'd3);
    check_pop("lb_data");
    check("lb_ready", {63'b0, lsu_ready}, 64'd1);

    // lbu back-to-back on the exit edge
    next();
    issue_load(64'h8000_0003, 3'b100, 64'h0000_0000_8000_0000, 64'h80);
    check("lbu_latency", 64'(n), 64'd3);
    check_pop("lbu_data");

    next();
    issue_load(64'h0000_0002, 3'b001, 64'h0000_0000_F00D_0000, 64'hFFFF_FFFF_FFFF_F00D);
    check_pop("lh_data");
    next();
    issue_load(64'h0000_0004, 3'b010, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
    check_pop("lw_data");
    next();
    issue_load(64'h0000_0004, 3'b110, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
    check_pop("lwu_data");
    next();
    issue_load(64'h0000_0000, 3'b011, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567);
    check_pop("ld_data");

    // pass-through
    next();
    idle_inputs(); lsu_valid = 1'b1; settle();
    check("pass_valid", {63'b0, lsu_to_wbu_valid}, 64'd1);
    check("pass_ready", {63'b0, lsu_ready}, 64'd1);
    check("pass_nobus", {59'b0, arvalid, rready, awvalid, wvalid, bready}, 64'd0);
    wbu_allow_in = 1'b0; settle();
    check("pass_stall_ready", {63'b0, lsu_ready}, 64'd0);
    pipeline_flush = 1'b1; wbu_allow_in = 1'b1; settle();
    check("pass_flush_valid", {63'b0, lsu_to_wbu_valid}, 64'd0);

    // memory op flushed in IDLE is dropped
    i_MemRd = 1'b1; settle();
    next(); settle();
    check("idle_flush_noar", {63'b0, arvalid}, 64'd0);

    // sh: AW accepted two cycles before W, delayed B
    next();
    idle_inputs(); lsu_valid = 1'b1; i_MemWr = 1'b1; i_MemOP = 3'b001;
    i_addr = 64'h8000_0006; i_wdata = 64'h1234;
    awready = 1'b1; wready = 1'b0; bvalid = 1'b0; settle();
    check("sh_idle_valid", {63'b0, lsu_to_wbu_valid}, 64'd0);
    next(); settle();
    check("sh_awvalid", {63'b0, awvalid}, 64'd1);
    check("sh_wvalid", {63'b0, wvalid}, 64'd1);
    check("sh_wstrb", {56'b0, wstrb}, 64'hC0);
    check("sh_wdata", wdata, 64'h1234_0000_0000_0000);
    check("sh_awaddr", awaddr, 64'h8000_0006);
    next(); settle();
    check("sh_aw_dropped", {63'b0, awvalid}, 64'd0);
    check("sh_w_held", {63'b0, wvalid}, 64'd1);
    next(); wready = 1'b1; settle();
    check("sh_w_held2", {63'b0, wvalid}, 64'd1);
    check("sh_busy_valid", {63'b0, lsu_to_wbu_valid}, 64'd0);
    next(); wready = 1'b0; settle();
    check("sh_bready", {63'b0, bready}, 64'd1);
    check("sh_wreq_done", {62'b0, awvalid, wvalid}, 64'd0);
    next(); settle();
    check("sh_wait_b", {63'b0, lsu_to_wbu_valid}, 64'd0);
    bvalid = 1'b1;
    next(); bvalid = 1'b0; settle();
    check("sh_done_valid", {63'b0, lsu_to_wbu_valid}, 64'd1);
    check("sh_done_ready", {63'b0, lsu_ready}, 64'd1);

    // backpressure: DONE held for 4 cycles
    next();
    idle_inputs(); wbu_allow_in = 1'b0;
    issue_load(64'h0000_0001, 3'b100, 64'h0000_0000_0000_A500, 64'hA5);
    check("bp_latency", 64'(n), 64'd3);
    check_pop("bp_data");
    for (int i = 0; i < 3; i++) begin
      next(); settle();
      check("bp_hold_valid", {63'b0, lsu_to_wbu_valid}, 64'd1);
      check("bp_hold_ready", {63'b0, lsu_ready}, 64'd0);
      check("bp_hold_data", o_rdata, 64'hA5);
    end
    next(); wbu_allow_in = 1'b1; settle();
    check("bp_release_ready", {63'b0, lsu_ready}, 64'd1);
    next(); idle_inputs(); settle();
    check("bp_single_xfer", {63'b0, lsu_to_wbu_valid}, 64'd0);

    // flush in RDATA with rvalid delayed
    next();
    rvalid = 1'b0; arready = 1'b1;
    lsu_valid = 1'b1; i_MemRd = 1'b1; i_MemOP = 3'b011; i_addr = 64'h10; rdata = 64'h55;
    settle();
    next(); settle();
    check("fl_arvalid", {63'b0, arvalid}, 64'd1);
    next(); pipeline_flush = 1'b1; settle();
    check("fl_rready0", {63'b0, rready}, 64'd1);
    check("fl_valid0", {63'b0, lsu_to_wbu_valid}, 64'd0);
    next(); pipeline_flush = 1'b0; i_MemRd = 1'b0; settle();
    for (int i = 0; i < 2; i++) begin
      check("fl_rready_hold", {63'b0, rready}, 64'd1);
      check("fl_busy_valid", {63'b0, lsu_to_wbu_valid}, 64'd0);
      check("fl_busy_ready", {63'b0, lsu_ready}, 64'd0);
      next(); settle();
    end
    rvalid = 1'b1; settle();
    check("fl_rready_last", {63'b0, rready}, 64'd1);
    check("fl_valid_last", {63'b0, lsu_to_wbu_valid}, 64'd0);
    next(); rvalid = 1'b0; settle();
    check("fl_next_valid", {63'b0, lsu_to_wbu_valid}, 64'd1);
    check("fl_next_ready", {63'b0, lsu_ready}, 64'd1);
    check("fl_no_rready", {63'b0, rready}, 64'd0);

    // asynchronous reset during WREQ
    next();
    idle_inputs(); lsu_valid = 1'b1; i_MemWr = 1'b1; i_MemOP = 3'b011; i_addr = 64'h8;
    awready = 1'b0; wready = 1'b0; settle();
    next(); settle();
    check("rs_awvalid_pre", {63'b0, awvalid}, 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rs_axi_drop", {59'b0, arvalid, rready, awvalid, wvalid, bready}, 64'd0);
    check("rs_valid_drop", {62'b0, lsu_ready, lsu_to_wbu_valid}, 64'd0);
    check("rs_rdata", o_rdata, 64'd0);
    next(); rst = 1'b0; i_MemWr = 1'b0; settle();
    check("rs_idle_pass", {63'b0, lsu_to_wbu_valid}, 64'd1);
    check("rs_idle_noaw", {63'b0, awvalid}, 64'd0);

    next(); idle_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
